setup_controller: RTL and testbench

//  Initiator side of the setup_on/setup_end handshake with the setup editor block.

---
 rtl/door_pkg.sv | 58 +++++
 rtl/setup_sanitize.sv | 31 +++
 rtl/setup_controller.sv | 136 +++++++++++++
 tb/tb_setup_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// Shared types and constants for the door setup path: BCD digits, pin
// records, the full 100-bit setup record, its power-on default and the
// setup_controller state encoding.
package door_pkg;

    typedef logic [3:0] bcdPac_t;

    typedef struct packed {
        logic    status;
        bcdPac_t digit1;
        bcdPac_t digit2;
        bcdPac_t digit3;
        bcdPac_t digit4;
    } pinPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranca_aut_time;
        pinPac_t    master_pin;
        pinPac_t    pin1;
        pinPac_t    pin2;
        pinPac_t    pin3;
        pinPac_t    pin4;
    } setupPac_t;

    localparam setupPac_t CFG_DEFAULT = '{
        bip_status:      1'b1,
        bip_time:        7'd5,
        tranca_aut_time: 7'd5,
        master_pin:      '{1'b1, 4'd1, 4'd2, 4'd3, 4'd4},
        pin1:            '{1'b1, 4'd0, 4'd0, 4'd0, 4'd0},
        pin2:            '0,
        pin3:            '0,
        pin4:            '0
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        RELEASE = 2'd2
    } setup_ctrl_state_t;

    // A pin is usable only if every digit is a decimal digit
    function automatic logic pin_valid(input pinPac_t p);
        return (p.digit1 <= 4'd9) && (p.digit2 <= 4'd9) &&
               (p.digit3 <= 4'd9) && (p.digit4 <= 4'd9);
    endfunction

    function automatic logic [6:0] clamp_time(input logic [6:0] t,
                                              input logic [6:0] lo,
                                              input logic [6:0] hi);
        if (t < lo)      return lo;
        else if (t > hi) return hi;
        else             return t;
    endfunction

endpackage

// File: rtl/setup_sanitize.sv
// Combinational cleanup of an editor-proposed setup record against the live
// one: clamps the two timers, locks the master pin, keeps pin1 enabled and
// rejects any pin that carries a non-decimal digit.
module setup_sanitize
    import door_pkg::*;
#(
    parameter int MIN_TIME = 5,
    parameter int MAX_TIME = 60
) (
    input  setupPac_t cfg_new_i,
    input  setupPac_t cfg_old_i,
    output setupPac_t cfg_o
);

    localparam logic [6:0] MIN_T = 7'(MIN_TIME);
    localparam logic [6:0] MAX_T = 7'(MAX_TIME);

    // Start from the proposal and override the fields the editor may not own
    always_comb begin
        cfg_o                 = cfg_new_i;
        cfg_o.bip_time        = clamp_time(cfg_new_i.bip_time, MIN_T, MAX_T);
        cfg_o.tranca_aut_time = clamp_time(cfg_new_i.tranca_aut_time, MIN_T, MAX_T);
        cfg_o.master_pin      = cfg_old_i.master_pin;
        if (!pin_valid(cfg_new_i.pin1)) cfg_o.pin1 = cfg_old_i.pin1;
        if (!pin_valid(cfg_new_i.pin2)) cfg_o.pin2 = cfg_old_i.pin2;
        if (!pin_valid(cfg_new_i.pin3)) cfg_o.pin3 = cfg_old_i.pin3;
        if (!pin_valid(cfg_new_i.pin4)) cfg_o.pin4 = cfg_old_i.pin4;
        cfg_o.pin1.status     = 1'b1;
    end

endmodule

// File: rtl/setup_controller.sv
// Initiator side of the setup_on/setup_end handshake with the setup editor.
// Owns the live configuration and commits sanitised editor data.
// Optional feature macro: SETUP_TIMEOUT_EN adds an ARM-state watchdog that
// abandons the session (setup_abort pulse) after TIMEOUT_CYCLES cycles.
//
// state   | meaning
// IDLE    | no session; accepts (or defers) setup_request
// ARM     | setup_on=1, editor owns the session; waiting for setup_end=0
// RELEASE | setup_on=0, waiting for editor to return setup_end=1
module setup_controller
    import door_pkg::*;
#(
    parameter int          MIN_TIME       = 5,
    parameter int          MAX_TIME       = 60,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd30_000_000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      setup_request,
    input  logic      setup_end,
    input  setupPac_t data_setup_new,
    output logic      setup_on,
    output setupPac_t data_setup_old,
    output logic      setup_active,
    output logic      cfg_updated,
    output logic      setup_abort
);

    setup_ctrl_state_t state_q, state_d;
    logic              pending_q, pending_d;
    logic              setup_on_q, setup_on_d;
    logic              updated_q, updated_d;
    setupPac_t         cfg_q, cfg_d;
    setupPac_t         cfg_clean;
`ifdef SETUP_TIMEOUT_EN
    logic [31:0]       cnt_q, cnt_d;
    logic              abort_q, abort_d;
`endif

    setup_sanitize #(
        .MIN_TIME (MIN_TIME),
        .MAX_TIME (MAX_TIME)
    ) u_sanitize (
        .cfg_new_i (data_setup_new),
        .cfg_old_i (cfg_q),
        .cfg_o     (cfg_clean)
    );

    // Next-state and registered-output decisions
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        setup_on_d = setup_on_q;
        updated_d  = 1'b0;
        cfg_d      = cfg_q;
`ifdef SETUP_TIMEOUT_EN
        cnt_d      = '0;
        abort_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A request seen while the editor is still busy is remembered
                if (setup_request || pending_q) begin
                    if (setup_end) begin
                        state_d    = ARM;
                        setup_on_d = 1'b1;
                        pending_d  = 1'b0;
                    end else begin
                        pending_d  = 1'b1;
                    end
                end
            end
            ARM: begin
`ifdef SETUP_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (!setup_end) begin
                    cfg_d      = cfg_clean;
                    updated_d  = 1'b1;
                    setup_on_d = 1'b0;
                    state_d    = RELEASE;
                end
`ifdef SETUP_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    setup_on_d = 1'b0;
                    abort_d    = 1'b1;
                    state_d    = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (setup_end) state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                setup_on_d = 1'b0;
            end
        endcase
    end

    // State and configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            setup_on_q <= 1'b0;
            updated_q  <= 1'b0;
            cfg_q      <= CFG_DEFAULT;
`ifdef SETUP_TIMEOUT_EN
            cnt_q      <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            setup_on_q <= setup_on_d;
            updated_q  <= updated_d;
            cfg_q      <= cfg_d;
`ifdef SETUP_TIMEOUT_EN
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign setup_on       = setup_on_q;
    assign data_setup_old = cfg_q;
    assign setup_active   = (state_q != IDLE);
    assign cfg_updated    = updated_q;
`ifdef SETUP_TIMEOUT_EN
    assign setup_abort    = abort_q;
`else
    assign setup_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_setup_controller.sv
module tb_setup_controller;
    import door_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      setup_request;
    logic      setup_end;
    setupPac_t data_setup_new;
    logic      setup_on;
    setupPac_t data_setup_old;
    logic      setup_active;
    logic      cfg_updated;
    logic      setup_abort;

    int n_pass = 0;
    int n_total = 0;
    setupPac_t exp_cfg;

    always #5 clk = ~clk;

    setup_controller #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk            (clk),
        .rst            (rst),
        .setup_request  (setup_request),
        .setup_end      (setup_end),
        .data_setup_new (data_setup_new),
        .setup_on       (setup_on),
        .data_setup_old (data_setup_old),
        .setup_active   (setup_active),
        .cfg_updated    (cfg_updated),
        .setup_abort    (setup_abort)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plain request/edit/release sequence, used to move the DUT along
    task automatic do_session(input setupPac_t nd);
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        data_setup_new = nd;
        setup_end = 1'b0;
        step();
        setup_end = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        setup_request = 1'b0;
        setup_end = 1'b1;
        data_setup_new = CFG_DEFAULT;
        repeat (3) step();
        rst = 1'b1;
        step();
        n_total++;
        if (setup_on !== 1'b0) $display("FAIL reset_setup_on got %b want 0", setup_on);
        else n_pass++;
        n_total++;
        if (data_setup_old !== CFG_DEFAULT)
            $display("FAIL reset_cfg got %h want %h", data_setup_old, CFG_DEFAULT);
        else n_pass++;
        n_total++;
        if ({data_setup_old.master_pin.digit1, data_setup_old.master_pin.digit2,
             data_setup_old.master_pin.digit3, data_setup_old.master_pin.digit4} !== 16'h1234)
            $display("FAIL reset_master got %h want 1234", data_setup_old.master_pin);
        else n_pass++;
        n_total++;
        if ({cfg_updated, setup_active, setup_abort} !== 3'b000)
            $display("FAIL reset_flags got upd/act/abort=%b want 000",
                     {cfg_updated, setup_active, setup_abort});
        else n_pass++;
    endtask

    task automatic test_nominal();
        setupPac_t nd;
        nd = CFG_DEFAULT;
        nd.bip_time = 7'd30;
        nd.pin2 = '{1'b1, 4'd5, 4'd6, 4'd7, 4'd8};
        exp_cfg = nd;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        n_total++;
        if ({setup_on, setup_active} !== 2'b11)
            $display("FAIL nom_arm got on/act=%b want 11", {setup_on, setup_active});
        else n_pass++;
        data_setup_new = nd;
        step();
        n_total++;
        if (data_setup_old !== CFG_DEFAULT)
            $display("FAIL nom_no_early_commit got %h want %h", data_setup_old, CFG_DEFAULT);
        else n_pass++;
        setup_end = 1'b0;
        step();
        n_total++;
        if (data_setup_old !== exp_cfg)
            $display("FAIL nom_commit got %h want %h", data_setup_old, exp_cfg);
        else n_pass++;
        n_total++;
        if ({cfg_updated, setup_on} !== 2'b10)
            $display("FAIL nom_capture_flags got upd/on=%b want 10", {cfg_updated, setup_on});
        else n_pass++;
        step();
        n_total++;
        if ({cfg_updated, setup_active} !== 2'b01)
            $display("FAIL nom_release got upd/act=%b want 01", {cfg_updated, setup_active});
        else n_pass++;
        setup_end = 1'b1;
        step();
        n_total++;
        if (setup_active !== 1'b0) $display("FAIL nom_idle got act=%b want 0", setup_active);
        else n_pass++;
    endtask

    task automatic test_sanitise();
        setupPac_t nd;
        // Session 1: upper/lower clamp, bad pin3, forged master, pin1 disabled
        nd = exp_cfg;
        nd.bip_time = 7'd70;
        nd.tranca_aut_time = 7'd2;
        nd.pin3 = '{1'b1, 4'd1, 4'hA, 4'd3, 4'd4};
        nd.master_pin = '{1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
        nd.pin1.status = 1'b0;
        nd.pin4 = '{1'b0, 4'd9, 4'd0, 4'd0, 4'd1};
        do_session(nd);
        exp_cfg.bip_time = 7'd60;
        exp_cfg.tranca_aut_time = 7'd5;
        exp_cfg.pin4 = '{1'b0, 4'd9, 4'd0, 4'd0, 4'd1};
        n_total++;
        if ({data_setup_old.bip_time, data_setup_old.tranca_aut_time} !== {7'd60, 7'd5})
            $display("FAIL san1_times got %0d/%0d want 60/5",
                     data_setup_old.bip_time, data_setup_old.tranca_aut_time);
        else n_pass++;
        n_total++;
        if (data_setup_old.pin3 !== pinPac_t'(17'h0))
            $display("FAIL san1_pin3_kept got %h want 00000", data_setup_old.pin3);
        else n_pass++;
        n_total++;
        if (data_setup_old.master_pin !== CFG_DEFAULT.master_pin)
            $display("FAIL san1_master got %h want %h", data_setup_old.master_pin,
                     CFG_DEFAULT.master_pin);
        else n_pass++;
        n_total++;
        if (data_setup_old.pin1.status !== 1'b1)
            $display("FAIL san1_pin1_status got %b want 1", data_setup_old.pin1.status);
        else n_pass++;
        n_total++;
        if (data_setup_old !== exp_cfg)
            $display("FAIL san1_full got %h want %h", data_setup_old, exp_cfg);
        else n_pass++;
        // Session 2: 61->60, 60 passes, status bits pass through, bad pin4
        nd = exp_cfg;
        nd.bip_time = 7'd61;
        nd.tranca_aut_time = 7'd60;
        nd.bip_status = 1'b0;
        nd.pin1 = '{1'b0, 4'd7, 4'd7, 4'd7, 4'd7};
        nd.pin2 = '{1'b0, 4'd9, 4'd9, 4'd9, 4'd9};
        nd.pin3 = '{1'b1, 4'd9, 4'd4, 4'd4, 4'd9};
        nd.pin4 = '{1'b1, 4'd1, 4'd1, 4'd1, 4'hF};
        do_session(nd);
        exp_cfg.bip_time = 7'd60;
        exp_cfg.tranca_aut_time = 7'd60;
        exp_cfg.bip_status = 1'b0;
        exp_cfg.pin1 = '{1'b1, 4'd7, 4'd7, 4'd7, 4'd7};
        exp_cfg.pin2 = '{1'b0, 4'd9, 4'd9, 4'd9, 4'd9};
        exp_cfg.pin3 = '{1'b1, 4'd9, 4'd4, 4'd4, 4'd9};
        n_total++;
        if (data_setup_old !== exp_cfg)
            $display("FAIL san2_full got %h want %h", data_setup_old, exp_cfg);
        else n_pass++;
        // Session 3: 4->5, 127->60, 5 passes, bad pin1 keeps old pin1
        nd = exp_cfg;
        nd.bip_time = 7'd4;
        nd.tranca_aut_time = 7'd127;
        nd.pin1 = '{1'b0, 4'd1, 4'd2, 4'd3, 4'hA};
        do_session(nd);
        exp_cfg.bip_time = 7'd5;
        exp_cfg.tranca_aut_time = 7'd60;
        n_total++;
        if (data_setup_old !== exp_cfg)
            $display("FAIL san3_full got %h want %h", data_setup_old, exp_cfg);
        else n_pass++;
        nd = exp_cfg;
        nd.tranca_aut_time = 7'd5;
        do_session(nd);
        exp_cfg.tranca_aut_time = 7'd5;
        n_total++;
        if (data_setup_old.tranca_aut_time !== 7'd5)
            $display("FAIL san4_min_pass got %0d want 5", data_setup_old.tranca_aut_time);
        else n_pass++;
    endtask

    task automatic test_gating();
        setup_end = 1'b0;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        n_total++;
        if (setup_on !== 1'b0) $display("FAIL gate_deferred got on=%b want 0", setup_on);
        else n_pass++;
        step();
        step();
        n_total++;
        if ({setup_on, setup_active} !== 2'b00)
            $display("FAIL gate_still_deferred got on/act=%b want 00", {setup_on, setup_active});
        else n_pass++;
        setup_end = 1'b1;
        step();
        n_total++;
        if (setup_on !== 1'b1) $display("FAIL gate_pending_arm got on=%b want 1", setup_on);
        else n_pass++;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        n_total++;
        if ({setup_on, cfg_updated} !== 2'b10)
            $display("FAIL gate_req_in_arm got on/upd=%b want 10", {setup_on, cfg_updated});
        else n_pass++;
        data_setup_new = exp_cfg;
        setup_end = 1'b0;
        step();
        n_total++;
        if ({setup_on, cfg_updated} !== 2'b01 || data_setup_old !== exp_cfg)
            $display("FAIL gate_capture got on/upd=%b cfg=%h want 01 cfg=%h",
                     {setup_on, cfg_updated}, data_setup_old, exp_cfg);
        else n_pass++;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        setup_end = 1'b1;
        step();
        step();
        step();
        n_total++;
        if ({setup_on, setup_active} !== 2'b00)
            $display("FAIL gate_no_rearm got on/act=%b want 00", {setup_on, setup_active});
        else n_pass++;
    endtask

    task automatic test_timeout();
`ifdef SETUP_TIMEOUT_EN
        setupPac_t nd;
        int bad;
        bad = 0;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        repeat (15) begin
            step();
            if (setup_on !== 1'b1 || setup_abort !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL to_early got %0d bad cycles want 0", bad);
        else n_pass++;
        step();
        n_total++;
        if ({setup_abort, setup_on, cfg_updated} !== 3'b100 || data_setup_old !== exp_cfg)
            $display("FAIL to_abort got abort/on/upd=%b cfg=%h want 100 cfg=%h",
                     {setup_abort, setup_on, cfg_updated}, data_setup_old, exp_cfg);
        else n_pass++;
        step();
        n_total++;
        if ({setup_abort, setup_active} !== 2'b00)
            $display("FAIL to_after got abort/act=%b want 00", {setup_abort, setup_active});
        else n_pass++;
        // Capture on the timeout cycle wins
        nd = exp_cfg;
        nd.bip_time = 7'd42;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        repeat (15) step();
        data_setup_new = nd;
        setup_end = 1'b0;
        step();
        exp_cfg.bip_time = 7'd42;
        n_total++;
        if ({setup_abort, cfg_updated} !== 2'b01 || data_setup_old !== exp_cfg)
            $display("FAIL to_capture_wins got abort/upd=%b cfg=%h want 01 cfg=%h",
                     {setup_abort, cfg_updated}, data_setup_old, exp_cfg);
        else n_pass++;
        setup_end = 1'b1;
        step();
`else
        int bad;
        bad = 0;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        repeat (40) begin
            step();
            if (setup_on !== 1'b1 || setup_abort !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL no_to_wait got %0d bad cycles want 0", bad);
        else n_pass++;
        data_setup_new = exp_cfg;
        setup_end = 1'b0;
        step();
        setup_end = 1'b1;
        step();
`endif
    endtask

    task automatic test_reset_mid();
        setupPac_t nd;
        nd = exp_cfg;
        nd.bip_time = 7'd33;
        setup_request = 1'b1;
        step();
        setup_request = 1'b0;
        data_setup_new = nd;
        n_total++;
        if (setup_on !== 1'b1) $display("FAIL mid_arm got on=%b want 1", setup_on);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({setup_on, setup_active} !== 2'b00 || data_setup_old !== CFG_DEFAULT)
            $display("FAIL mid_async got on/act=%b cfg=%h want 00 cfg=%h",
                     {setup_on, setup_active}, data_setup_old, CFG_DEFAULT);
        else n_pass++;
        setup_end = 1'b0;
        step();
        rst = 1'b1;
        setup_end = 1'b1;
        step();
        n_total++;
        if ({setup_on, cfg_updated} !== 2'b00 || data_setup_old !== CFG_DEFAULT)
            $display("FAIL mid_after got on/upd=%b cfg=%h want 00 cfg=%h",
                     {setup_on, cfg_updated}, data_setup_old, CFG_DEFAULT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sanitise();
        test_gating();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
